// File: rtl/rename_rat_if.sv
// Rename-stage bundle: decoded group in, free-list allocation handshake,
// and the registered renamed group out to dispatch/ROB.
interface rename_rat_if #(
  parameter int MACHINE_WIDTH = 4,
  parameter int ARF_WIDTH     = 5,
  parameter int PRF_WIDTH     = 7
);
  logic [MACHINE_WIDTH-1:0]                dec_valid;
  logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0] dec_rs1;
  logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0] dec_rs2;
  logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0] dec_rd;
  logic [MACHINE_WIDTH-1:0]                dec_rd_we;
  logic                                    dec_ready;

  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] free_prn;
  logic [MACHINE_WIDTH-1:0]                free_prn_valid;
  logic [MACHINE_WIDTH-1:0]                free_prn_ready;

  logic [MACHINE_WIDTH-1:0]                rn_valid;
  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rn_prs1;
  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rn_prs2;
  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rn_prd;
  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rn_prd_prev;
  logic [MACHINE_WIDTH-1:0]                rn_rd_we;
  logic                                    rn_ready;

  // master: decode / free list / dispatch side; slave: the rename table
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we,
    input  dec_ready,
    output free_prn, free_prn_valid,
    input  free_prn_ready,
    input  rn_valid, rn_prs1, rn_prs2, rn_prd, rn_prd_prev, rn_rd_we,
    output rn_ready
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we,
    output dec_ready,
    input  free_prn, free_prn_valid,
    output free_prn_ready,
    output rn_valid, rn_prs1, rn_prs2, rn_prd, rn_prd_prev, rn_rd_we,
    input  rn_ready
  );
endinterface

// File: rtl/rename_rat.sv
// Speculative register alias table: renames a MACHINE_WIDTH-wide group per
// cycle with intra-group bypass, positional free-list allocation, and recovery.
module rename_rat #(
  parameter int MACHINE_WIDTH = 4,
  parameter int ARF_DEPTH     = 32,
  parameter int PRF_WIDTH     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  rename_rat_if.slave          io,
  input  logic [PRF_WIDTH-1:0] arch_rat [ARF_DEPTH],
  input  logic                 recov_arch_st
);
  localparam int ARF_WIDTH = 5;
  localparam int W         = MACHINE_WIDTH;

  logic [PRF_WIDTH-1:0] spec_rat [ARF_DEPTH];

  logic [W-1:0] need;
  logic         prn_ok;
  logic         out_free;
  logic         fire;

  logic [W-1:0][PRF_WIDTH-1:0] ren_prs1, ren_prs2, ren_prd, ren_prev;

  logic [W-1:0]                rn_valid_q, rn_rd_we_q;
  logic [W-1:0][PRF_WIDTH-1:0] rn_prs1_q, rn_prs2_q, rn_prd_q, rn_prev_q;

  always_comb begin
    need   = '0;
    prn_ok = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      need[i] = io.dec_valid[i] && io.dec_rd_we[i] && (io.dec_rd[i] != '0);
      if (need[i] && !io.free_prn_valid[i]) prn_ok = 1'b0;
    end
  end

  assign out_free     = !(|rn_valid_q) || io.rn_ready;
  assign io.dec_ready = out_free && !recov_arch_st && prn_ok;
  // Reset also blocks the group so nothing is allocated while rst is high.
  assign fire         = (|io.dec_valid) && out_free && !recov_arch_st && prn_ok && !rst;

  always_comb begin
    io.free_prn_ready = '0;
    for (int unsigned i = 0; i < W; i++)
      io.free_prn_ready[i] = fire && need[i];
  end

  // Ascending scan over older slots leaves the youngest matching writer in place.
  always_comb begin
    ren_prs1 = '0;
    ren_prs2 = '0;
    ren_prd  = '0;
    ren_prev = '0;
    for (int unsigned j = 0; j < W; j++) begin
      ren_prs1[j] = spec_rat[io.dec_rs1[j]];
      ren_prs2[j] = spec_rat[io.dec_rs2[j]];
      ren_prev[j] = spec_rat[io.dec_rd[j]];
      for (int unsigned k = 0; k < j; k++) begin
        if (need[k] && io.dec_rd[k] == io.dec_rs1[j]) ren_prs1[j] = io.free_prn[k];
        if (need[k] && io.dec_rd[k] == io.dec_rs2[j]) ren_prs2[j] = io.free_prn[k];
        if (need[k] && io.dec_rd[k] == io.dec_rd[j])  ren_prev[j] = io.free_prn[k];
      end
      if (io.dec_rs1[j] == '0) ren_prs1[j] = '0;
      if (io.dec_rs2[j] == '0) ren_prs2[j] = '0;
      if (need[j]) ren_prd[j]  = io.free_prn[j];
      else         ren_prev[j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned a = 0; a < ARF_DEPTH; a++) spec_rat[a] <= '0;
      rn_valid_q <= '0;
      rn_rd_we_q <= '0;
      rn_prs1_q  <= '0;
      rn_prs2_q  <= '0;
      rn_prd_q   <= '0;
      rn_prev_q  <= '0;
    end else if (recov_arch_st) begin
      for (int unsigned a = 0; a < ARF_DEPTH; a++) spec_rat[a] <= arch_rat[a];
      rn_valid_q <= '0;
    end else if (fire) begin
      // Later slots overwrite earlier ones, so the youngest same-rd writer wins.
      for (int unsigned i = 0; i < W; i++)
        if (need[i]) spec_rat[io.dec_rd[i]] <= io.free_prn[i];
      rn_valid_q <= io.dec_valid;
      rn_rd_we_q <= need;
      rn_prs1_q  <= ren_prs1;
      rn_prs2_q  <= ren_prs2;
      rn_prd_q   <= ren_prd;
      rn_prev_q  <= ren_prev;
    end else if (io.rn_ready) begin
      rn_valid_q <= '0;
    end
  end

  assign io.rn_valid    = rn_valid_q;
  assign io.rn_rd_we    = rn_rd_we_q;
  assign io.rn_prs1     = rn_prs1_q;
  assign io.rn_prs2     = rn_prs2_q;
  assign io.rn_prd      = rn_prd_q;
  assign io.rn_prd_prev = rn_prev_q;

  logic unused_width;
  assign unused_width = ARF_WIDTH[0];
endmodule

// File: tb/tb_rename_rat.sv
// Directed bench for rename_rat: vector table for single-group renames plus
// hand sequences for backpressure, recovery and mid-stream reset.
module tb_rename_rat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic recov_arch_st = 1'b0;
  logic [6:0] arch_rat [32];

  int total = 0;
  int bad   = 0;

  rename_rat_if #(.MACHINE_WIDTH(4), .ARF_WIDTH(5), .PRF_WIDTH(7)) rif ();

  rename_rat #(.MACHINE_WIDTH(4), .ARF_DEPTH(32), .PRF_WIDTH(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (rif.slave),
    .arch_rat     (arch_rat),
    .recov_arch_st(recov_arch_st)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [3:0]       valid, we, fpv;
    logic [3:0][4:0]  rs1, rs2, rd;
    logic [3:0][6:0]  prn;
    logic             e_ready;
    logic [3:0]       e_fpr, e_valid, e_we;
    logic [3:0][6:0]  e_prs1, e_prs2, e_prd, e_prev;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic clr(output vec_t x, input string n);
    x.name = n;    x.valid = '0;   x.we = '0;     x.fpv = '0;
    x.rs1 = '0;    x.rs2 = '0;     x.rd = '0;     x.prn = '0;
    x.e_ready = 1'b1; x.e_fpr = '0; x.e_valid = '0; x.e_we = '0;
    x.e_prs1 = '0; x.e_prs2 = '0;  x.e_prd = '0;  x.e_prev = '0;
  endtask

  task automatic drive(input vec_t x);
    rif.dec_valid = x.valid;  rif.dec_rd_we = x.we;
    rif.dec_rs1 = x.rs1;      rif.dec_rs2 = x.rs2;  rif.dec_rd = x.rd;
    rif.free_prn = x.prn;     rif.free_prn_valid = x.fpv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t g;
    for (int a = 0; a < 32; a++) arch_rat[a] = '0;
    clr(g, "idle");
    drive(g);
    rif.rn_ready = 1'b1;

    // ---- vector table ----
    clr(v[0], "x5_after_reset");
    v[0].valid = 4'b0001; v[0].we = 4'b0001; v[0].rd[0] = 5; v[0].rs1[0] = 5;
    v[0].prn[0] = 10; v[0].fpv = 4'b0001;
    v[0].e_fpr = 4'b0001; v[0].e_valid = 4'b0001; v[0].e_we = 4'b0001;
    v[0].e_prd[0] = 10;

    clr(v[1], "x5_now_10");
    v[1].valid = 4'b0001; v[1].rs1[0] = 5; v[1].rs2[0] = 5;
    v[1].e_valid = 4'b0001; v[1].e_prs1[0] = 10; v[1].e_prs2[0] = 10;

    clr(v[2], "x3_bypass");
    v[2].valid = 4'b1111; v[2].fpv = 4'b1001;
    v[2].we[0] = 1; v[2].rd[0] = 3; v[2].prn[0] = 12;
    v[2].rs1[1] = 5;
    v[2].rs1[2] = 3; v[2].rs2[2] = 3;
    v[2].we[3] = 1; v[2].rd[3] = 3; v[2].rs1[3] = 3; v[2].prn[3] = 15;
    v[2].e_fpr = 4'b1001; v[2].e_valid = 4'b1111; v[2].e_we = 4'b1001;
    v[2].e_prd[0] = 12;
    v[2].e_prs1[1] = 10;
    v[2].e_prs1[2] = 12; v[2].e_prs2[2] = 12;
    v[2].e_prs1[3] = 12; v[2].e_prd[3] = 15; v[2].e_prev[3] = 12;

    clr(v[3], "x3_is_15_x9_collide");
    v[3].valid = 4'b0011; v[3].we = 4'b0011; v[3].fpv = 4'b0011;
    v[3].rd[0] = 9; v[3].rs1[0] = 3; v[3].prn[0] = 30;
    v[3].rd[1] = 9; v[3].rs2[1] = 3; v[3].prn[1] = 31;
    v[3].e_fpr = 4'b0011; v[3].e_valid = 4'b0011; v[3].e_we = 4'b0011;
    v[3].e_prs1[0] = 15; v[3].e_prd[0] = 30;
    v[3].e_prs2[1] = 15; v[3].e_prd[1] = 31; v[3].e_prev[1] = 30;

    clr(v[4], "missing_prn_stall");
    v[4].valid = 4'b0011; v[4].rs1[0] = 9;
    v[4].we[1] = 1; v[4].rd[1] = 4; v[4].prn[1] = 33; v[4].fpv = 4'b0001;
    v[4].e_ready = 1'b0;

    clr(v[5], "x0_gap_fires");
    v[5].valid = 4'b0011; v[5].rs1[0] = 9; v[5].rs2[0] = 4;
    v[5].we[1] = 1; v[5].rd[1] = 0; v[5].fpv = 4'b0001;
    v[5].e_valid = 4'b0011; v[5].e_prs1[0] = 31;

    clr(v[6], "slot2_only");
    v[6].valid = 4'b0100; v[6].we[2] = 1; v[6].rd[2] = 6; v[6].rs1[2] = 6;
    v[6].prn[2] = 40; v[6].prn[0] = 99; v[6].fpv = 4'b0100;
    v[6].e_fpr = 4'b0100; v[6].e_valid = 4'b0100; v[6].e_we = 4'b0100;
    v[6].e_prd[2] = 40;

    clr(v[7], "empty_group");

    // ---- reset ----
    repeat (2) tick();
    chk("rst_rn_valid", rif.rn_valid, 0);
    chk("rst_rn_prd", rif.rn_prd, 0);
    chk("rst_rn_rd_we", rif.rn_rd_we, 0);
    rst = 1'b0;
    #1;
    chk("rst_dec_ready", rif.dec_ready, 1);

    for (int n = 0; n < 8; n++) begin
      drive(v[n]);
      #1;
      chk({v[n].name, ".dec_ready"}, rif.dec_ready, v[n].e_ready);
      chk({v[n].name, ".free_prn_ready"}, rif.free_prn_ready, v[n].e_fpr);
      tick();
      chk({v[n].name, ".rn_valid"}, rif.rn_valid, v[n].e_valid);
      if (v[n].e_valid != 0) begin
        chk({v[n].name, ".rn_rd_we"}, rif.rn_rd_we, v[n].e_we);
        for (int s = 0; s < 4; s++) begin
          chk($sformatf("%s.prs1[%0d]", v[n].name, s), rif.rn_prs1[s], v[n].e_prs1[s]);
          chk($sformatf("%s.prs2[%0d]", v[n].name, s), rif.rn_prs2[s], v[n].e_prs2[s]);
          chk($sformatf("%s.prd[%0d]", v[n].name, s), rif.rn_prd[s], v[n].e_prd[s]);
          chk($sformatf("%s.prev[%0d]", v[n].name, s), rif.rn_prd_prev[s], v[n].e_prev[s]);
        end
      end
    end

    // ---- backpressure: full output held for 3 cycles ----
    clr(g, "full");
    g.valid = 4'b1111; g.we = 4'b1111; g.fpv = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      g.rd[s] = 5'(10 + s);
      g.prn[s] = 7'(50 + s);
    end
    drive(g);
    rif.rn_ready = 1'b0;
    #1;
    chk("bp_load_ready", rif.dec_ready, 1);
    tick();
    chk("bp_loaded", rif.rn_valid, 4'b1111);
    clr(g, "next");
    g.valid = 4'b0001; g.we = 4'b0001; g.rd[0] = 14; g.rs1[0] = 10;
    g.prn[0] = 60; g.fpv = 4'b0001;
    drive(g);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_dec_ready", rif.dec_ready, 0);
      chk("bp_fpr", rif.free_prn_ready, 0);
      tick();
      chk("bp_rn_valid", rif.rn_valid, 4'b1111);
      for (int s = 0; s < 4; s++) chk("bp_prd_hold", rif.rn_prd[s], 50 + s);
    end
    rif.rn_ready = 1'b1;
    #1;
    chk("bp_release_ready", rif.dec_ready, 1);
    chk("bp_release_fpr", rif.free_prn_ready, 4'b0001);
    tick();
    chk("bp_next_valid", rif.rn_valid, 4'b0001);
    chk("bp_next_prd", rif.rn_prd[0], 60);
    chk("bp_next_prs1", rif.rn_prs1[0], 50);

    // ---- recovery from arch_rat ----
    arch_rat[7] = 20;
    recov_arch_st = 1'b1;
    rif.rn_ready = 1'b0;
    clr(g, "during_recov");
    g.valid = 4'b0001; g.we = 4'b0001; g.rd[0] = 8; g.prn[0] = 70; g.fpv = 4'b0001;
    drive(g);
    #1;
    chk("recov_dec_ready", rif.dec_ready, 0);
    chk("recov_fpr", rif.free_prn_ready, 0);
    tick();
    chk("recov_rn_valid", rif.rn_valid, 0);
    recov_arch_st = 1'b0;
    rif.rn_ready = 1'b1;
    clr(g, "after_recov");
    g.valid = 4'b0001; g.we = 4'b0001; g.rd[0] = 8; g.rs1[0] = 7; g.rs2[0] = 14;
    g.prn[0] = 71; g.fpv = 4'b0001;
    drive(g);
    #1;
    chk("post_recov_fpr", rif.free_prn_ready, 4'b0001);
    tick();
    chk("post_recov_valid", rif.rn_valid, 4'b0001);
    chk("post_recov_prs1_x7", rif.rn_prs1[0], 20);
    chk("post_recov_prs2_x14", rif.rn_prs2[0], 0);
    chk("post_recov_prev_x8", rif.rn_prd_prev[0], 0);
    chk("post_recov_prd", rif.rn_prd[0], 71);

    // ---- reset mid-stream ----
    rst = 1'b1;
    rif.rn_ready = 1'b0;
    clr(g, "during_rst");
    g.valid = 4'b0001; g.we = 4'b0001; g.rd[0] = 5; g.prn[0] = 90; g.fpv = 4'b0001;
    drive(g);
    tick();
    chk("midrst_rn_valid", rif.rn_valid, 0);
    rif.rn_ready = 1'b1;
    #1;
    chk("midrst_fpr", rif.free_prn_ready, 0);
    tick();
    chk("midrst_dropped", rif.rn_valid, 0);
    rst = 1'b0;
    clr(g, "after_rst");
    g.valid = 4'b0001; g.we = 4'b0001; g.rd[0] = 5; g.rs1[0] = 8; g.rs2[0] = 7;
    g.prn[0] = 91; g.fpv = 4'b0001;
    drive(g);
    tick();
    chk("postrst_valid", rif.rn_valid, 4'b0001);
    chk("postrst_prs1_x8", rif.rn_prs1[0], 0);
    chk("postrst_prs2_x7", rif.rn_prs2[0], 0);
    chk("postrst_prev_x5", rif.rn_prd_prev[0], 0);
    chk("postrst_prd", rif.rn_prd[0], 91);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rename_rat.md
RENAME_RAT -- requirements
Module: rename_rat

Interface
REQ-001 SHALL have parameter MACHINE_WIDTH, default 4, meaning rename slots per cycle.
REQ-002 SHALL have parameter ARF_DEPTH, default 32, meaning architectural registers; ARF_WIDTH = 5.
REQ-003 SHALL have parameter PRF_WIDTH, default 7, meaning physical register tag width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have ports dec_valid[W]  in  W, dec_rs1/dec_rs2/dec_rd[W]  in  ARF_WIDTH each, dec_rd_we[W]  in  W, meaning the decoded group.
REQ-007 SHALL have port dec_ready  out  1  meaning the whole group is accepted this cycle.
REQ-008 SHALL have ports free_prn[W]  in  PRF_WIDTH, free_prn_valid  in  W, free_prn_ready  out  W, meaning the free-list allocation handshake.
REQ-009 SHALL have ports rn_valid  out  W, rn_prs1/rn_prs2/rn_prd/rn_prd_prev[W]  out  PRF_WIDTH, rn_rd_we  out  W, rn_ready  in  1, meaning the registered renamed group sent to dispatch/ROB.
REQ-010 SHALL have ports arch_rat[ARF_DEPTH]  in  PRF_WIDTH and recov_arch_st  in  1, meaning the retirement map used for mispredict recovery.

Function
REQ-011 SHALL hold a speculative map spec_rat[ARF_DEPTH] of PRF_WIDTH-bit tags.
REQ-012 SHALL define need[i] = dec_valid[i] && dec_rd_we[i] && dec_rd[i]!=0; x0 never allocates.
REQ-013 SHALL define out_free = !(|rn_valid) || rn_ready.
REQ-014 SHALL compute fire = (|dec_valid) && out_free && !recov_arch_st && (for every i, !need[i] || free_prn_valid[i]).
REQ-015 SHALL drive dec_ready = out_free && !recov_arch_st && (for every i, !need[i] || free_prn_valid[i]); the group is all-or-nothing.
REQ-016 SHALL allocate positionally: slot i takes free_prn[i]; free_prn_ready[i] = fire && need[i]; no allocation without fire.
REQ-017 SHALL rename sources of slot j as the free_prn of the youngest older slot k<j with need[k] and dec_rd[k]==src, else spec_rat[src]; a source of x0 SHALL yield tag 0.
REQ-018 SHALL set rd_prev of slot j by the same bypass rule as REQ-017 applied to dec_rd[j]; when need[j]=0, rn_prd=0 and rn_prd_prev=0.
REQ-019 SHALL, on fire, write spec_rat[dec_rd[i]] = free_prn[i] for every need[i]; on same-rd collision inside a group the youngest slot wins.
REQ-020 SHALL register results: on fire, the rn_* outputs load the group with rn_valid = dec_valid; on rn_ready without fire, rn_valid clears; otherwise the outputs hold stable (latency 1 cycle).
REQ-021 SHALL, on recov_arch_st, copy arch_rat into spec_rat, clear rn_valid, suppress fire/free_prn_ready, and give recovery priority over every other update that cycle.
REQ-022 SHALL keep rn_* data stable while rn_valid!=0 and rn_ready=0.
REQ-023 SHALL keep free_prn_valid gaps legal: a missing prn on a slot without need[i] SHALL not stall the group.

Reset
REQ-024 SHALL, on rst, set spec_rat[all]=0, rn_valid=0, rn_prs*/rn_prd/rn_prd_prev=0, rn_rd_we=0.
REQ-025 SHALL give rst priority over recov_arch_st and fire; a group presented while rst=1 SHALL be dropped with free_prn_ready=0.
REQ-026 SHALL drive dec_ready=0 only from the combinational terms above after reset; no extra warm-up cycles.

Verification
REQ-027 SHALL cover: after reset, slot0 rd=x5 rs1=x5, free_prn[0]=10 -> rn_prs1[0]=0, rn_prd[0]=10, rn_prd_prev[0]=0, spec_rat[5]=10 next cycle.
REQ-028 SHALL cover: slot0 rd=x3 (prn 12), slot2 rs1=x3 rs2=x3, slot3 rd=x3 (prn 15) -> slot2 prs1=prs2=12, slot3 prd_prev=12, spec_rat[3]=15.
REQ-029 SHALL cover: slot1 need=1 and free_prn_valid[1]=0 -> dec_ready=0, free_prn_ready=0, spec_rat unchanged; slot1 rd=x0 with free_prn_valid[1]=0 -> fire.
REQ-030 SHALL cover: rn_valid=4'b1111, rn_ready=0 for 3 cycles -> dec_ready=0, outputs stable; rn_ready=1 -> next group loads in the same cycle.
REQ-031 SHALL cover: recov_arch_st=1 with arch_rat[7]=20 while a group is valid -> no allocation, rn_valid=0 next cycle, spec_rat[7]=20, then x7 source renames to 20.
REQ-032 SHALL cover: rst asserted mid-stream with rn_valid set -> rn_valid=0 and spec_rat all 0 the next cycle.
